// File: rtl/vn_output_collector.sv
// Captures one batch of switch VN lanes and serializes its valid lanes, lowest index first.
// Optional beat/drop counters are built when VN_COLLECTOR_COUNT_EN is defined.
module vn_output_collector #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SW     = 4,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [2*NUM_SW*DATA_WIDTH-1:0] i_vn,
    input  logic [2*NUM_SW-1:0]            i_vn_valid,
    output logic                           o_stall,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic [IDX_W-1:0]               o_idx,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_ovf,
`ifdef VN_COLLECTOR_COUNT_EN
    output logic [15:0]                    o_beat_cnt,
    output logic [7:0]                     o_drop_cnt,
`endif
    input  logic                           i_clr_ovf
);

    localparam int unsigned LANES = 2 * NUM_SW;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [LANES*DATA_WIDTH-1:0]   r_batch;
    logic [LANES-1:0]              r_mask;
    logic [LANES-1:0]              w_mask_nxt;
    logic [LANES-1:0]              w_clr_bit;
    logic                          r_ovf;
    logic [IDX_W-1:0]              w_idx;
    logic [DATA_WIDTH-1:0]         w_data;
    logic                          w_valid;
    logic                          w_beat;
    logic                          w_last;
    logic                          w_batch_in;
    logic                          w_capture;
    logic                          w_drop;

    // Lowest pending lane wins; loop runs high to low so the last hit is the lowest.
    always_comb begin
        w_idx  = '0;
        w_data = '0;
        for (int k = int'(LANES) - 1; k >= 0; k--) begin
            if (r_mask[k]) begin
                w_idx  = IDX_W'(k);
                w_data = r_batch[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_valid    = |r_mask;
    assign w_beat     = w_valid & i_ready;
    assign w_last     = w_beat & ((r_mask & (r_mask - LANES'(1))) == '0);
    assign w_batch_in = |i_vn_valid;
    assign w_clr_bit  = LANES'(1) << w_idx;

    assign o_valid = w_valid;
    assign o_idx   = w_idx;
    assign o_data  = w_data;
    assign o_ovf   = r_ovf;

    // Next-state: a new batch is only taken while idle or on the beat that empties the mask.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        o_stall     = 1'b0;
        if (w_beat) begin
            w_mask_nxt = r_mask & ~w_clr_bit;
        end
        case (r_state)
            IDLE: begin
                if (w_batch_in) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                o_stall = !w_last;
                if (w_last) begin
                    if (w_batch_in) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_batch_in) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_capture) begin
            w_mask_nxt = i_vn_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_batch <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            if (w_capture) begin
                r_batch <= i_vn;
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef VN_COLLECTOR_COUNT_EN
    logic [15:0] r_beat_cnt;
    logic [7:0]  r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 16'(1);
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'(1);
            end
        end
    end

    assign o_beat_cnt = r_beat_cnt;
    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_vn_output_collector.sv
// Scoreboard bench for vn_output_collector: expected beats queued at stimulus, checked at output.
module tb_vn_output_collector;

    localparam int unsigned DW    = 32;
    localparam int unsigned NSW   = 4;
    localparam int unsigned IW    = 3;
    localparam int unsigned LANES = 2 * NSW;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [LANES*DW-1:0]   i_vn;
    logic [LANES-1:0]      i_vn_valid;
    logic                  o_stall;
    logic [DW-1:0]         o_data;
    logic [IW-1:0]         o_idx;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_ovf;
    logic                  i_clr_ovf;
`ifdef VN_COLLECTOR_COUNT_EN
    logic [15:0]           o_beat_cnt;
    logic [7:0]            o_drop_cnt;
`endif

    int    n_vec = 0;
    int    n_err = 0;
    beat_t sb_q[$];

    vn_output_collector #(.DATA_WIDTH(DW), .NUM_SW(NSW), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_vn       (i_vn),
        .i_vn_valid (i_vn_valid),
        .o_stall    (o_stall),
        .o_data     (o_data),
        .o_idx      (o_idx),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_ovf      (o_ovf),
`ifdef VN_COLLECTOR_COUNT_EN
        .o_beat_cnt (o_beat_cnt),
        .o_drop_cnt (o_drop_cnt),
`endif
        .i_clr_ovf  (i_clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives lane k = base+k; queues the lanes expected to come out if the batch is accepted.
    task automatic drive_batch(input logic [LANES-1:0] mask, input logic [DW-1:0] base, input bit exp_acc);
        beat_t b;
        for (int k = 0; k < int'(LANES); k++) begin
            i_vn[k*DW +: DW] = base + DW'(k);
            if (exp_acc && mask[k]) begin
                b.idx  = IW'(k);
                b.data = base + DW'(k);
                sb_q.push_back(b);
            end
        end
        i_vn_valid = mask;
    endtask

    // Every accepted beat is compared with the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                check("stray_beat", 64'(o_valid), 64'd0);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                check("beat_idx", 64'(o_idx), 64'(e.idx));
                check("beat_data", 64'(o_data), 64'(e.data));
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        i_vn       = '0;
        i_vn_valid = '0;
        i_ready    = 1'b1;
        i_clr_ovf  = 1'b0;
        #2;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_data",  64'(o_data),  64'd0);
        check("rst_idx",   64'(o_idx),   64'd0);
        check("rst_stall", 64'(o_stall), 64'd0);
        check("rst_ovf",   64'(o_ovf),   64'd0);
        #10 rst_n = 1'b1;
        next_cyc();

        // Single batch, lanes 0,2,5,7
        drive_batch(8'hA5, 32'h3F80_0000, 1'b1);
        @(negedge clk);
        check("s1_valid_T", 64'(o_valid), 64'd0);
        check("s1_stall_T", 64'(o_stall), 64'd0);
        next_cyc();
        i_vn_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("s1_valid", 64'(o_valid), 64'd1);
            check("s1_stall", 64'(o_stall), (c < 4) ? 64'd1 : 64'd0);
            next_cyc();
        end
        @(negedge clk);
        check("s1_done_valid", 64'(o_valid), 64'd0);
        check("s1_q_empty", 64'(sb_q.size()), 64'd0);
        next_cyc();

        // Overflow: second batch arrives while four lanes are pending
        drive_batch(8'h0F, 32'h4000_0000, 1'b1);
        next_cyc();
        drive_batch(8'hF0, 32'h5000_0000, 1'b0);
        @(negedge clk);
        check("s4_stall", 64'(o_stall), 64'd1);
        next_cyc();
        i_vn_valid = '0;
        @(negedge clk);
        check("s4_ovf_set", 64'(o_ovf), 64'd1);
        next_cyc();
        next_cyc();
        @(negedge clk);
        check("s4_last_stall", 64'(o_stall), 64'd0);
        next_cyc();
        @(negedge clk);
        check("s4_done_valid", 64'(o_valid), 64'd0);
        check("s4_q_empty", 64'(sb_q.size()), 64'd0);
`ifdef VN_COLLECTOR_COUNT_EN
        check("beat_cnt", 64'(o_beat_cnt), 64'd8);
        check("drop_cnt", 64'(o_drop_cnt), 64'd1);
`endif
        next_cyc();
        i_clr_ovf = 1'b1;
        @(negedge clk);
        check("s4_ovf_hold", 64'(o_ovf), 64'd1);
        next_cyc();
        i_clr_ovf = 1'b0;
        @(negedge clk);
        check("s4_ovf_clr", 64'(o_ovf), 64'd0);
        next_cyc();

        // Backpressure: head beat held for three cycles
        i_ready = 1'b0;
        drive_batch(8'hA5, 32'h3F80_0000, 1'b1);
        next_cyc();
        i_vn_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("s2_hold_valid", 64'(o_valid), 64'd1);
            check("s2_hold_idx",   64'(o_idx),   64'd0);
            check("s2_hold_data",  64'(o_data),  64'h3F80_0000);
            check("s2_hold_stall", 64'(o_stall), 64'd1);
            next_cyc();
        end
        i_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("s2_valid", 64'(o_valid), 64'd1);
            next_cyc();
        end
        @(negedge clk);
        check("s2_done_valid", 64'(o_valid), 64'd0);
        check("s2_q_empty", 64'(sb_q.size()), 64'd0);
        next_cyc();

        // Back-to-back: B presented on A's final beat
        drive_batch(8'h01, 32'h1111_0000, 1'b1);
        @(negedge clk);
        check("s3_valid_T", 64'(o_valid), 64'd0);
        next_cyc();
        drive_batch(8'h80, 32'h2222_0000, 1'b1);
        @(negedge clk);
        check("s3_stall_last", 64'(o_stall), 64'd0);
        check("s3_idx_a", 64'(o_idx), 64'd0);
        next_cyc();
        i_vn_valid = '0;
        @(negedge clk);
        check("s3_valid_b", 64'(o_valid), 64'd1);
        check("s3_idx_b", 64'(o_idx), 64'd7);
        next_cyc();
        @(negedge clk);
        check("s3_done_valid", 64'(o_valid), 64'd0);
        check("s3_ovf", 64'(o_ovf), 64'd0);
        check("s3_q_empty", 64'(sb_q.size()), 64'd0);
        next_cyc();

        // Drop coincides with clear (set must win), then reset after two beats
        drive_batch(8'h0F, 32'h3333_0000, 1'b1);
        next_cyc();
        drive_batch(8'hF0, 32'h4444_0000, 1'b0);
        i_clr_ovf = 1'b1;
        @(negedge clk);
        check("s5_stall", 64'(o_stall), 64'd1);
        next_cyc();
        i_vn_valid = '0;
        i_clr_ovf  = 1'b0;
        @(negedge clk);
        check("s5_ovf_set_wins", 64'(o_ovf), 64'd1);
        next_cyc();
        #1 rst_n = 1'b0;
        #1;
        check("s5_rst_valid", 64'(o_valid), 64'd0);
        check("s5_rst_data",  64'(o_data),  64'd0);
        check("s5_rst_idx",   64'(o_idx),   64'd0);
        check("s5_rst_ovf",   64'(o_ovf),   64'd0);
        sb_q.delete();
        next_cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("s5_post_valid", 64'(o_valid), 64'd0);
            check("s5_post_stall", 64'(o_stall), 64'd0);
            next_cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
